// File: rtl/instr_mem_loadable_if.sv
// Bus bundle for instr_mem_loadable.
//   Load channel : load_start, load_valid, load_data, load_last (master->slave)
//                  load_ready (slave->master)
//   Read ports   : read_en[NUM_CORES], addr[NUM_CORES*WIDTH_ADDR] (master->slave)
//                  instr_out[NUM_CORES*WIDTH_INSTR], instr_valid[NUM_CORES] (slave->master)
//   Status       : mem_ready, prog_len[WIDTH_ADDR+1], load_err (slave->master)
// Per-core fields are packed with core c at [c*WIDTH +: WIDTH].
interface instr_mem_loadable_if #(
  parameter int WIDTH_ADDR  = 12,
  parameter int WIDTH_INSTR = 17,
  parameter int NUM_CORES   = 4
);
  logic                             load_start;
  logic                             load_valid;
  logic [WIDTH_INSTR-1:0]           load_data;
  logic                             load_last;
  logic                             load_ready;
  logic [NUM_CORES-1:0]             read_en;
  logic [NUM_CORES*WIDTH_ADDR-1:0]  addr;
  logic [NUM_CORES*WIDTH_INSTR-1:0] instr_out;
  logic [NUM_CORES-1:0]             instr_valid;
  logic                             mem_ready;
  logic [WIDTH_ADDR:0]              prog_len;
  logic                             load_err;

  modport master (
    output load_start, load_valid, load_data, load_last, read_en, addr,
    input  load_ready, instr_out, instr_valid, mem_ready, prog_len, load_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, read_en, addr,
    output load_ready, instr_out, instr_valid, mem_ready, prog_len, load_err
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory shared by NUM_CORES cores.
// A program is streamed in over the load channel (IDLE/LOAD/RUN session FSM);
// once loaded, every core gets an independent 1-cycle-latency read port.
// Reads past the program end, or issued before a program is loaded, return
// NOP_CODE.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset (RAM contents are kept)
//   bus  - instr_mem_loadable_if.slave: load channel, per-core read ports,
//          mem_ready / prog_len / load_err status
module instr_mem_loadable #(
  parameter int                     WIDTH_ADDR  = 12,
  parameter int                     WIDTH_INSTR = 17,
  parameter int                     DEPTH       = 2048,
  parameter int                     NUM_CORES   = 4,
  parameter logic [WIDTH_INSTR-1:0] NOP_CODE    = WIDTH_INSTR'(1)
) (
  input  logic                clk,
  input  logic                rst,
  instr_mem_loadable_if.slave bus
);

  localparam int                  IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH_ADDR:0] LAST_IDX = (WIDTH_ADDR + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t                           state;
  logic [WIDTH_ADDR:0]              wptr;
  logic                             load_err_q;
  logic                             load_ready_q;
  logic                             mem_ready_q;
  logic                             wr_en;
  logic                             running;
  logic [WIDTH_INSTR-1:0]           rd_word [NUM_CORES];
  logic [NUM_CORES*WIDTH_INSTR-1:0] out_q;
  logic [NUM_CORES-1:0]             valid_q;

  logic [WIDTH_INSTR-1:0] ram [DEPTH] = '{default: NOP_CODE};

  // A load_start in the same cycle as load_valid wins and the word is dropped.
  assign wr_en   = (state == S_LOAD) && bus.load_valid && !bus.load_start;
  assign running = (state == S_RUN);

  // Session FSM. wptr always equals the number of accepted words, so it is
  // exported directly as prog_len.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wptr         <= '0;
      load_err_q   <= 1'b0;
      load_ready_q <= 1'b0;
      mem_ready_q  <= 1'b0;
    end else if (bus.load_start) begin
      state        <= S_LOAD;
      wptr         <= '0;
      load_err_q   <= 1'b0;
      load_ready_q <= 1'b1;
      mem_ready_q  <= 1'b0;
    end else if (wr_en) begin
      wptr <= wptr + 1'b1;
      // Filling the last RAM slot without load_last ends the session with
      // an overflow flag instead of wrapping.
      if (bus.load_last || (wptr == LAST_IDX)) begin
        state        <= S_RUN;
        load_ready_q <= 1'b0;
        mem_ready_q  <= 1'b1;
        load_err_q   <= !bus.load_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wptr[IW-1:0]] <= bus.load_data;
    end
  end

  // Address truncation to IW bits is safe: the RAM word is only selected
  // when addr < prog_len <= DEPTH.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      rd_word[c] = NOP_CODE;
      if (running && ({1'b0, bus.addr[c*WIDTH_ADDR +: WIDTH_ADDR]} < wptr)) begin
        rd_word[c] = ram[bus.addr[c*WIDTH_ADDR +: IW]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= {NUM_CORES{NOP_CODE}};
      valid_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
        valid_q[c] <= bus.read_en[c] & running;
        if (bus.read_en[c]) begin
          out_q[c*WIDTH_INSTR +: WIDTH_INSTR] <= rd_word[c];
        end
      end
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.mem_ready   = mem_ready_q;
  assign bus.load_err    = load_err_q;
  assign bus.prog_len    = wptr;
  assign bus.instr_out   = out_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: a 2048-deep instance for the main
// load/read scenarios and a 4-deep instance for the overflow scenario.
module tb_instr_mem_loadable;

  localparam int             WA  = 12;
  localparam int             WI  = 17;
  localparam int             NC  = 4;
  localparam logic [WI-1:0]  NOP = 17'h00001;

  localparam int F_OUT = 0;
  localparam int F_VLD = 1;
  localparam int F_MR  = 2;
  localparam int F_LR  = 3;
  localparam int F_PL  = 4;
  localparam int F_LE  = 5;

  typedef struct {
    int          due;
    int          dut;
    int          fld;
    int          core;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_loadable_if #(.WIDTH_ADDR(WA), .WIDTH_INSTR(WI), .NUM_CORES(NC)) m ();
  instr_mem_loadable_if #(.WIDTH_ADDR(WA), .WIDTH_INSTR(WI), .NUM_CORES(NC)) s ();

  instr_mem_loadable #(
    .WIDTH_ADDR(WA), .WIDTH_INSTR(WI), .DEPTH(2048), .NUM_CORES(NC), .NOP_CODE(NOP)
  ) dut (
    .clk(clk), .rst(rst), .bus(m)
  );

  instr_mem_loadable #(
    .WIDTH_ADDR(WA), .WIDTH_INSTR(WI), .DEPTH(4), .NUM_CORES(NC), .NOP_CODE(NOP)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(s)
  );

  function automatic string fname(int fld);
    case (fld)
      F_OUT:   return "instr_out";
      F_VLD:   return "instr_valid";
      F_MR:    return "mem_ready";
      F_LR:    return "load_ready";
      F_PL:    return "prog_len";
      default: return "load_err";
    endcase
  endfunction

  function automatic logic [31:0] actual(int d, int fld, int core);
    logic [31:0] r;
    r = '0;
    if (d == 0) begin
      case (fld)
        F_OUT:   r = 32'(m.instr_out[core*WI +: WI]);
        F_VLD:   r = 32'(m.instr_valid[core]);
        F_MR:    r = 32'(m.mem_ready);
        F_LR:    r = 32'(m.load_ready);
        F_PL:    r = 32'(m.prog_len);
        default: r = 32'(m.load_err);
      endcase
    end else begin
      case (fld)
        F_OUT:   r = 32'(s.instr_out[core*WI +: WI]);
        F_VLD:   r = 32'(s.instr_valid[core]);
        F_MR:    r = 32'(s.mem_ready);
        F_LR:    r = 32'(s.load_ready);
        F_PL:    r = 32'(s.prog_len);
        default: r = 32'(s.load_err);
      endcase
    end
    return r;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expectations describe DUT outputs after the next rising edge.
  function automatic void push(int d, int fld, int core, logic [31:0] v);
    exp_t e;
    e.due  = cyc + 1;
    e.dut  = d;
    e.fld  = fld;
    e.core = core;
    e.val  = v;
    sb.push_back(e);
  endfunction

  function automatic void exp_status(int d, logic mr, logic lr, int pl, logic le);
    push(d, F_MR, 0, 32'(mr));
    push(d, F_LR, 0, 32'(lr));
    push(d, F_PL, 0, 32'(pl));
    push(d, F_LE, 0, 32'(le));
  endfunction

  function automatic void exp_read(int d, int c, logic v, logic [WI-1:0] data);
    push(d, F_VLD, c, 32'(v));
    push(d, F_OUT, c, 32'(data));
  endfunction

  // Monitor: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check($sformatf("%s.%s[%0d]", (e.dut == 0) ? "main" : "d4", fname(e.fld), e.core),
            actual(e.dut, e.fld, e.core), e.val);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m.load_start = 1'b0; m.load_valid = 1'b0; m.load_data = '0; m.load_last = 1'b0;
    m.read_en = '0; m.addr = '0;
    s.load_start = 1'b0; s.load_valid = 1'b0; s.load_data = '0; s.load_last = 1'b0;
    s.read_en = '0; s.addr = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state and a read while IDLE
    exp_status(0, 1'b0, 1'b0, 0, 1'b0);
    m.read_en = 4'b0001;
    m.addr    = '0;
    for (int c = 0; c < NC; c++) exp_read(0, c, 1'b0, NOP);
    tick();

    // Load a 3-word program
    m.read_en    = '0;
    m.load_start = 1'b1;
    exp_status(0, 1'b0, 1'b1, 0, 1'b0);
    tick();
    m.load_start = 1'b0;
    m.load_valid = 1'b1;
    m.load_data  = 17'h0C000;
    exp_status(0, 1'b0, 1'b1, 1, 1'b0);
    tick();
    m.load_data  = 17'h00011;
    push(0, F_PL, 0, 32'd2);
    tick();
    m.load_data  = 17'h00003;
    m.load_last  = 1'b1;
    exp_status(0, 1'b1, 1'b0, 3, 1'b0);
    tick();

    // All four cores read in the same cycle
    m.load_valid = 1'b0;
    m.load_last  = 1'b0;
    m.read_en    = 4'b1111;
    m.addr       = {12'd3, 12'd2, 12'd1, 12'd0};
    exp_read(0, 0, 1'b1, 17'h0C000);
    exp_read(0, 1, 1'b1, 17'h00011);
    exp_read(0, 2, 1'b1, 17'h00003);
    exp_read(0, 3, 1'b1, NOP);
    tick();

    // No request: valid drops, data held
    m.read_en = '0;
    exp_read(0, 0, 1'b0, 17'h0C000);
    exp_read(0, 2, 1'b0, 17'h00003);
    tick();

    // Read in the load_start cycle is served from the old program
    m.load_start = 1'b1;
    m.read_en    = 4'b0001;
    m.addr       = '0;
    exp_read(0, 0, 1'b1, 17'h0C000);
    exp_status(0, 1'b0, 1'b1, 0, 1'b0);
    tick();

    // Two words of a longer program, with a read during LOAD
    m.load_start = 1'b0;
    m.read_en    = 4'b0010;
    m.load_valid = 1'b1;
    m.load_data  = 17'h0AAAA;
    exp_read(0, 1, 1'b0, NOP);
    push(0, F_PL, 0, 32'd1);
    tick();
    m.read_en    = '0;
    m.load_data  = 17'h0BBBB;
    push(0, F_PL, 0, 32'd2);
    tick();

    // Restart mid-load; the simultaneous word is discarded
    m.load_start = 1'b1;
    m.load_data  = 17'h1FFFF;
    exp_status(0, 1'b0, 1'b1, 0, 1'b0);
    tick();
    m.load_start = 1'b0;
    m.load_data  = 17'h12345;
    m.load_last  = 1'b1;
    exp_status(0, 1'b1, 1'b0, 1, 1'b0);
    tick();
    m.load_valid = 1'b0;
    m.load_last  = 1'b0;
    m.read_en    = 4'b1111;
    m.addr       = {12'hFFF, 12'd1, 12'd1, 12'd0};
    exp_read(0, 0, 1'b1, 17'h12345);
    exp_read(0, 1, 1'b1, NOP);
    exp_read(0, 2, 1'b1, NOP);
    exp_read(0, 3, 1'b1, NOP);
    tick();
    m.read_en = '0;

    // Reset in the middle of a load
    m.load_start = 1'b1;
    push(0, F_LR, 0, 32'd1);
    tick();
    m.load_start = 1'b0;
    m.load_valid = 1'b1;
    m.load_data  = 17'h0DDDD;
    push(0, F_PL, 0, 32'd1);
    tick();
    m.load_data  = 17'h0EEEE;
    push(0, F_PL, 0, 32'd2);
    tick();
    m.load_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst.load_ready", 32'(m.load_ready), 32'd0);
    check("async_rst.prog_len", 32'(m.prog_len), 32'd0);
    check("async_rst.mem_ready", 32'(m.mem_ready), 32'd0);
    tick();
    rst = 1'b0;
    exp_status(0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    m.load_start = 1'b1;
    push(0, F_LR, 0, 32'd1);
    tick();
    m.load_start = 1'b0;
    m.load_valid = 1'b1;
    m.load_data  = 17'h00077;
    m.load_last  = 1'b1;
    exp_status(0, 1'b1, 1'b0, 1, 1'b0);
    tick();
    m.load_valid = 1'b0;
    m.load_last  = 1'b0;
    m.read_en    = 4'b0011;
    m.addr       = {12'd0, 12'd0, 12'd1, 12'd0};
    exp_read(0, 0, 1'b1, 17'h00077);
    exp_read(0, 1, 1'b1, NOP);
    tick();
    m.read_en = '0;

    // Overflow on the 4-deep instance
    s.load_start = 1'b1;
    exp_status(1, 1'b0, 1'b1, 0, 1'b0);
    tick();
    s.load_start = 1'b0;
    s.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s.load_data = WI'(32'h101 + i);
      if (i < 3) exp_status(1, 1'b0, 1'b1, i + 1, 1'b0);
      else       exp_status(1, 1'b1, 1'b0, 4, 1'b1);
      tick();
    end
    s.load_data = 17'h00105;
    exp_status(1, 1'b1, 1'b0, 4, 1'b1);
    tick();
    s.load_valid = 1'b0;
    s.read_en    = 4'b0011;
    s.addr       = {12'd0, 12'd0, 12'd4, 12'd3};
    exp_read(1, 0, 1'b1, 17'h00104);
    exp_read(1, 1, 1'b1, NOP);
    tick();
    s.read_en    = '0;
    s.load_start = 1'b1;
    exp_status(1, 1'b0, 1'b1, 0, 1'b0);
    tick();
    s.load_start = 1'b0;

    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 SHALL have parameter WIDTH_ADDR, default 12, instruction address width.
REQ-002 SHALL have parameter WIDTH_INSTR, default 17, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 2048, number of instruction words (DEPTH <= 2^WIDTH_ADDR).
REQ-004 SHALL have parameter NUM_CORES, default 4, number of independent read ports.
REQ-005 SHALL have parameter NOP_CODE, default 1, instruction returned for invalid reads.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port load_start, input, 1, starts or restarts a program load session.
REQ-009 SHALL have port load_valid, input, 1, load_data is valid.
REQ-010 SHALL have port load_data, input, WIDTH_INSTR, instruction word to store.
REQ-011 SHALL have port load_last, input, 1, marks final word of program.
REQ-012 SHALL have port load_ready, output, 1, block accepts load words.
REQ-013 SHALL have port read_en, input, NUM_CORES, per-core read request.
REQ-014 SHALL have port addr, input, NUM_CORES*WIDTH_ADDR, per-core address; core c in bits [c*WIDTH_ADDR +: WIDTH_ADDR].
REQ-015 SHALL have port instr_out, output, NUM_CORES*WIDTH_INSTR, per-core instruction, same packing.
REQ-016 SHALL have port instr_valid, output, NUM_CORES, per-core read data valid.
REQ-017 SHALL have port mem_ready, output, 1, a program is loaded and reads are served.
REQ-018 SHALL have port prog_len, output, WIDTH_ADDR+1, number of words in current program.
REQ-019 SHALL have port load_err, output, 1, sticky overflow flag for last load.

Function
REQ-020 SHALL implement states IDLE, LOAD, RUN; mem_ready = 1 only in RUN; load_ready = 1 only in LOAD.
REQ-021 SHALL go IDLE->LOAD and RUN->LOAD on load_start, clearing write pointer, prog_len and load_err in that cycle.
REQ-022 SHALL, in LOAD, accept a word when load_valid and load_ready: write ram[wptr] = load_data, wptr += 1, prog_len = wptr+1.
REQ-023 SHALL go LOAD->RUN on the cycle after an accepted word with load_last = 1.
REQ-024 SHALL, when the DEPTH-th word is accepted with load_last = 0, go to RUN and set load_err = 1; load_err holds until next load_start.
REQ-025 SHALL restart the session (wptr = 0, prog_len = 0) on load_start while in LOAD; a simultaneous load_valid word is discarded.
REQ-026 SHALL ignore load_valid/load_data/load_last outside LOAD.
REQ-027 SHALL serve each core independently with 1-cycle latency: read_en[c] at edge N -> instr_out[c], instr_valid[c] updated at edge N+1.
REQ-028 SHALL return ram[addr_c] with instr_valid[c] = 1 when state is RUN and addr_c < prog_len.
REQ-029 SHALL return NOP_CODE with instr_valid[c] = 1 when state is RUN and addr_c >= prog_len.
REQ-030 SHALL return NOP_CODE with instr_valid[c] = 0 when read_en[c] = 1 in IDLE or LOAD.
REQ-031 SHALL hold instr_out[c] and drive instr_valid[c] = 0 when read_en[c] = 0.
REQ-032 SHALL let a read issued in the same cycle as load_start in RUN be served from the old program.
REQ-033 SHALL support all NUM_CORES reads to the same or different addresses in one cycle without stalls.

Reset
REQ-034 SHALL, on rst high, asynchronously set state IDLE, wptr 0, prog_len 0, load_err 0, load_ready 0, mem_ready 0, instr_valid all 0, instr_out all NOP_CODE.
REQ-035 SHALL leave RAM contents unchanged by rst; RAM SHALL power up filled with NOP_CODE.
REQ-036 SHALL abort an in-progress load on rst; RUN is re-entered only through a new complete load.

Verification
REQ-037 Reset, load 3 words 0x0C000,0x00011,0x00003 (last on 3rd) -> prog_len 3, mem_ready 1 next cycle, load_err 0.
REQ-038 RUN, cores 0..3 read addr 0,1,2,3 same cycle -> next cycle instr_out = 0x0C000,0x00011,0x00003,NOP_CODE, instr_valid = 4'b1111.
REQ-039 Load with DEPTH=4, 4 words no load_last -> RUN, load_err 1, prog_len 4; 5th load_valid ignored, load_ready 0.
REQ-040 Read in IDLE after reset, addr 0 -> instr_out NOP_CODE, instr_valid 0; mem_ready 0.
REQ-041 Mid-load (2 of 5 words) assert load_start, then load 1 word with last -> prog_len 1; read addr 1 returns NOP_CODE, valid 1.
REQ-042 Assert rst mid-load -> immediately state IDLE, load_ready 0, prog_len 0; previously written RAM words readable after a later 1-word reload only at addr 0.
